// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin sharing of one uart_tx serializer among N_REQ message sources.
// Latency: grant 1 clk after req seen in IDLE; tx_valid 2 clks after LATCH entry.
// Backpressure: one byte in flight; next byte waits for busy drop plus GAP_CYCLES; grant locked per message.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_byte,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_valid,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  output logic               timeout_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             timeout_err_q, timeout_err_d;
  logic             last_q, last_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic [15:0]      gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    pick;
  logic             found;
  int               sum;

  // Round-robin pick: rotate req so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot   = N_REQ'({req, req} >> rr_ptr_q);
    found = 1'b0;
    pick  = '0;
    sum   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = int'(rr_ptr_q) + i;
        if (sum >= N_REQ) sum = sum - N_REQ;
        pick  = IW'(sum);
      end
    end
  end

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    req_ready_d   = '0;
    tx_valid_d    = tx_valid_q;
    tx_byte_d     = tx_byte_q;
    timeout_err_d = 1'b0;
    last_d        = last_q;
    busy_cnt_d    = busy_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          idx_d   = pick;
          grant_d = N_REQ'(1) << pick;
          state_d = LATCH;
        end
      end
      LATCH: begin
        tx_byte_d          = req_byte[{idx_q, 3'b000} +: 8];
        last_d             = req_last[idx_q];
        req_ready_d[idx_q] = 1'b1;
        state_d            = SEND;
      end
      SEND: begin
        tx_valid_d = 1'b1;
        busy_cnt_d = '0;
        state_d    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = WAIT_DONE;
        end else if (busy_cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
          // Serializer never accepted the byte: drop it and carry on with the message.
          tx_valid_d    = 1'b0;
          timeout_err_d = 1'b1;
          gap_cnt_d     = '0;
          state_d       = GAP;
        end else begin
          busy_cnt_d = busy_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          gap_cnt_d = '0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt_q == 16'(GAP_CYCLES - 1)) begin
          if (last_q || !req[idx_q]) begin
            grant_d  = '0;
            rr_ptr_d = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = LATCH;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any message in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      req_ready_q   <= '0;
      tx_valid_q    <= 1'b0;
      tx_byte_q     <= 8'h00;
      timeout_err_q <= 1'b0;
      last_q        <= 1'b0;
      busy_cnt_q    <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      req_ready_q   <= req_ready_d;
      tx_valid_q    <= tx_valid_d;
      tx_byte_q     <= tx_byte_d;
      timeout_err_q <= timeout_err_d;
      last_q        <= last_d;
      busy_cnt_q    <= busy_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign grant       = grant_q;
  assign tx_valid    = tx_valid_q;
  assign tx_byte     = tx_byte_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and uart_tx models advance on the falling edge,
// monitors sample there too, directed messages with hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int N        = 2;
  localparam int GAP      = 8;
  localparam int BT       = 10;
  localparam int BUSY_LEN = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_valid;
  logic [7:0]     tx_byte;
  logic           tx_busy;
  logic           timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_byte    (req_byte),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_valid    (tx_valid),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // requester models
  logic [7:0] msg   [N][8];
  logic       lastf [N][8];
  int         len   [N];
  int         ptr   [N];
  bit         act   [N];

  // uart_tx model
  bit mute;
  int busy_cnt;

  // monitors
  int          cyc;
  logic        vprev;
  logic [N-1:0] gprev;
  int          vrun, vfree, n_to, onehot_bad;
  int          rdy_cnt [N];
  int          gedge   [N];
  int          drop_cyc;
  bit          drop_pend;
  logic [15:0] log_q [$];
  int          runs  [$];
  int          gaps  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_pins();
    for (int i = 0; i < N; i++) begin
      req[i]             = act[i];
      req_byte[8*i +: 8] = (ptr[i] < 8) ? msg[i][ptr[i][2:0]] : 8'h00;
      req_last[i]        = (ptr[i] < 8) ? lastf[i][ptr[i][2:0]] : 1'b0;
    end
  endtask

  task automatic set_msg(input int r, input logic [63:0] bytes, input logic [7:0] lasts, input int n);
    for (int k = 0; k < 8; k++) begin
      msg[r][k]   = bytes[8*k +: 8];
      lastf[r][k] = lasts[k];
    end
    len[r] = n;
    ptr[r] = 0;
  endtask

  task automatic clear_mon();
    log_q.delete();
    runs.delete();
    gaps.delete();
    vfree = 0; n_to = 0; onehot_bad = 0; drop_pend = 0; vrun = 0;
    for (int i = 0; i < N; i++) begin
      rdy_cnt[i] = 0;
      gedge[i]   = 0;
    end
  endtask

  // One clock: sample DUT at the falling edge, then advance the models.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if ((grant & (grant - 1'b1)) != '0) onehot_bad++;
    for (int i = 0; i < N; i++) begin
      if (grant[i] && !gprev[i]) gedge[i]++;
      if (req_ready[i]) begin
        rdy_cnt[i]++;
        ptr[i]++;
        if (ptr[i] >= len[i]) act[i] = 1'b0;
      end
    end
    gprev = grant;
    if (tx_valid && !vprev) begin
      log_q.push_back(16'({grant, tx_byte}));
      if (drop_pend) begin
        gaps.push_back(cyc - drop_cyc);
        drop_pend = 0;
      end
    end
    if (tx_valid) vrun++;
    else if (vrun > 0) begin
      runs.push_back(vrun);
      vrun = 0;
    end
    if (tx_valid && !tx_busy) vfree++;
    if (timeout_err) n_to++;
    vprev = tx_valid;
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        tx_busy   = 1'b0;
        drop_cyc  = cyc;
        drop_pend = 1;
      end
    end else if (tx_valid && !tx_busy && !mute) begin
      tx_busy  = 1'b1;
      busy_cnt = BUSY_LEN;
    end
    drive_pins();
  endtask

  function automatic bit any_act();
    bit a = 0;
    for (int i = 0; i < N; i++) a |= act[i];
    return a;
  endfunction

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (k < budget && (any_act() || grant != '0)) begin
      tick();
      k++;
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic check_log(input string tag, input int idx, input logic [15:0] exp);
    logic [15:0] got;
    got = (idx < log_q.size()) ? log_q[idx] : 16'hFFFF;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    tx_busy = 1'b0; busy_cnt = 0; mute = 0;
    cyc = 0; vprev = 1'b0; gprev = '0; drop_cyc = 0;
    for (int i = 0; i < N; i++) begin
      set_msg(i, 64'h0, 8'h0, 0);
      act[i] = 1'b0;
    end
    clear_mon();
    drive_pins();

    // reset state
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_grant", 32'(grant), 32'd0);

    // contention: req 0 carries two 2-byte messages back to back, req 1 one
    clear_mon();
    set_msg(0, 64'hA3A2A1A0, 8'b1010, 4);
    set_msg(1, 64'hB1B0, 8'b10, 2);
    act[0] = 1'b1; act[1] = 1'b1;
    drive_pins();
    wait_done("t2_done", 2000);
    check("t2_nbytes", 32'(log_q.size()), 32'd6);
    check_log("t2_b0", 0, 16'h01A0);
    check_log("t2_b1", 1, 16'h01A1);
    check_log("t2_b2", 2, 16'h02B0);
    check_log("t2_b3", 3, 16'h02B1);
    check_log("t2_b4", 4, 16'h01A2);
    check_log("t2_b5", 5, 16'h01A3);
    check("t2_onehot", 32'(onehot_bad), 32'd0);
    check("t2_gedge0", 32'(gedge[0]), 32'd2);
    check("t2_gedge1", 32'(gedge[1]), 32'd1);
    check("t2_rdy0", 32'(rdy_cnt[0]), 32'd4);
    check("t2_rdy1", 32'(rdy_cnt[1]), 32'd2);

    // single requester "OK\n", plus inter-byte gap timing
    clear_mon();
    set_msg(0, 64'h0A4B4F, 8'b100, 3);
    act[0] = 1'b1;
    drive_pins();
    wait_done("t1_done", 1000);
    check("t1_nbytes", 32'(log_q.size()), 32'd3);
    check_log("t1_b0", 0, 16'h014F);
    check_log("t1_b1", 1, 16'h014B);
    check_log("t1_b2", 2, 16'h010A);
    check("t1_rdy0", 32'(rdy_cnt[0]), 32'd3);
    check("t1_gedge0", 32'(gedge[0]), 32'd1);
    check("t1_gedge1", 32'(gedge[1]), 32'd0);
    check("t1_grant_end", 32'(grant), 32'd0);
    check("t1_valid_before_busy", 32'(vfree), 32'd3);
    check("t1_no_timeout", 32'(n_to), 32'd0);
    check("t6_ngaps", 32'(gaps.size()), 32'd2);
    check("t6_gap0", 32'((gaps.size() > 0) ? gaps[0] : -1), 32'd11);
    check("t6_gap1", 32'((gaps.size() > 1) ? gaps[1] : -1), 32'd11);

    // busy never rises: each byte times out after BT cycles
    clear_mon();
    mute = 1;
    set_msg(0, 64'h2221, 8'b10, 2);
    act[0] = 1'b1;
    drive_pins();
    wait_done("t3_done", 1000);
    check("t3_nruns", 32'(runs.size()), 32'd2);
    check("t3_run0", 32'((runs.size() > 0) ? runs[0] : -1), 32'd10);
    check("t3_run1", 32'((runs.size() > 1) ? runs[1] : -1), 32'd10);
    check("t3_timeouts", 32'(n_to), 32'd2);
    check("t3_rdy0", 32'(rdy_cnt[0]), 32'd2);
    check_log("t3_b1", 1, 16'h0122);
    check("t3_grant_end", 32'(grant), 32'd0);
    mute = 0;

    // early req drop by requester 0 while requester 1 waits
    clear_mon();
    set_msg(0, 64'h3534333231, 8'b10000, 1);
    set_msg(1, 64'h41, 8'b1, 1);
    act[0] = 1'b1;
    drive_pins();
    k = 0;
    while (k < 10 && grant != 2'b01) begin tick(); k++; end
    check("t4_grant0", 32'(grant), 32'd1);
    act[1] = 1'b1;
    drive_pins();
    k = 0;
    while (k < 200 && grant == 2'b01) begin tick(); k++; end
    check("t4_release", 32'(grant), 32'd0);
    tick();
    check("t4_grant1", 32'(grant), 32'd2);
    wait_done("t4_done", 500);
    check("t4_nbytes", 32'(log_q.size()), 32'd2);
    check_log("t4_b0", 0, 16'h0131);
    check_log("t4_b1", 1, 16'h0241);
    check("t4_rdy0", 32'(rdy_cnt[0]), 32'd1);

    // async reset during WAIT_DONE, then restart of the message
    clear_mon();
    set_msg(0, 64'h636261, 8'b100, 3);
    act[0] = 1'b1;
    drive_pins();
    k = 0;
    while (k < 60 && !tx_busy) begin tick(); k++; end
    check("t5_busy", 32'(tx_busy), 32'd1);
    repeat (3) tick();
    check("t5_grant_pre", 32'(grant), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd0);
    check("t5_timeout_err", 32'(timeout_err), 32'd0);
    check("t5_tx_byte", 32'(tx_byte), 32'd0);
    tx_busy = 1'b0; busy_cnt = 0;
    ptr[0] = 0;
    drive_pins();
    repeat (2) tick();
    clear_mon();
    rst_n = 1'b1;
    wait_done("t5_done", 1000);
    check("t5_nbytes", 32'(log_q.size()), 32'd3);
    check_log("t5_b0", 0, 16'h0161);
    check_log("t5_b2", 2, 16'h0163);
    check("t5_rdy0", 32'(rdy_cnt[0]), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ independent message sources: debug dump, PPU trace, bus trace. Requesters hold a request for a whole message and stream it one byte at a time. The arbiter grants round-robin and drives uart_tx's data_valid/byte/busy handshake per byte. It inserts a fixed inter-byte gap and locks the grant until the message ends. It replaces the per-module tx state machines, so several debug blocks can share the single tx pin.

Parameters:
N_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 8, idle clk cycles after uart_tx drops busy before the next byte is presented (>=1)
BUSY_TIMEOUT, 255, clk cycles to wait for tx_busy to rise after tx_valid before the byte is dropped (>=2, <=255)

Ports:
clk  in  1  system clock (same clk as uart_tx); single clock domain
rst_n  in  1  asynchronous, active-low reset
req  in  N_REQ  per-requester message request; held high for the entire message
req_byte  in  8*N_REQ  current byte per requester; requester i drives slice [8i+7:8i]
req_last  in  N_REQ  current byte is the final byte of the message
req_ready  out  N_REQ  one-cycle pulse: current byte latched; requester advances to next byte next cycle
grant  out  N_REQ  one-hot owner of the serializer, all zero when idle
tx_valid  out  1  to uart_tx data_valid
tx_byte  out  8  to uart_tx byte
tx_busy  in  1  from uart_tx busy
timeout_err  out  1  one-cycle pulse when a byte is dropped on BUSY_TIMEOUT

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, req_ready=0, tx_valid=0, tx_byte=8'h00, timeout_err=0, rr_ptr=0, counters=0.
- Reset mid-message: everything aborts immediately; the interrupted requester keeps req high and gets no further req_ready. Requesters must restart the message after reset.
- States: IDLE, LATCH, SEND, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if req!=0, pick the first set bit searching upward from rr_ptr with wrap. Register it one-hot into grant. Go to LATCH. No grant is issued when req==0.
- LATCH (one cycle): tx_byte<=req_byte[g], last_q<=req_last[g], req_ready[g]<=1 for exactly this cycle's output. Go to SEND.
- SEND: tx_valid<=1, timeout count=0. Go to WAIT_BUSY.
- WAIT_BUSY: tx_valid stays 1 until tx_busy is sampled high.
  - On tx_busy: tx_valid<=0, go to WAIT_DONE.
  - On count reaching BUSY_TIMEOUT first: tx_valid<=0, timeout_err pulse, go to GAP. The byte counts as consumed.
- WAIT_DONE: wait for tx_busy low, then go to GAP with gap count=0.
- GAP: count GAP_CYCLES cycles, then:
  - if last_q or req[g] is low: release. grant<=0, rr_ptr<=(g+1) mod N_REQ, go to IDLE.
  - else: go to LATCH for the next byte.
- Latency: from LATCH entry to tx_valid high is 2 cycles. The minimum byte period is 3 + busy duration + GAP_CYCLES cycles.
- req deasserted mid-message: the current byte finishes normally, then the grant is released at the end of GAP. The requester must not drop req until its last req_ready.
- A requester asserting req while another owns grant waits; no preemption.
- Simultaneous requests: round-robin fairness. After an owner is released, every other active requester is served before that owner again.
- A single-byte message (req_last high on the first byte) is legal.
- tx_byte is stable from LATCH until the next LATCH.
- req_ready, timeout_err, grant and tx_valid are registered outputs with no combinational paths from inputs.

Test Plan:
1. Single requester. req[0]=1, bytes "OK\n" with req_last on '\n'; uart_tx model busy for 20 cycles per byte. Required: tx_byte sequence 4F,4B,0A; exactly 3 req_ready[0] pulses; grant=01 throughout, then 00; tx_valid high 1 cycle per byte before busy.
2. Contention. req=11 asserted in the same cycle, each sending a 2-byte message, rr_ptr=0. Required: both bytes of requester 0 go out, then both bytes of requester 1; grant is 01 then 10, never both. On re-request by both, requester 1 is served first.
3. Busy timeout. BUSY_TIMEOUT=10 and the model never raises busy. Required: tx_valid high for exactly 10 cycles per byte; one timeout_err pulse per byte; the message still completes and grant is released.
4. Early req drop. Requester 0 drops req after its first req_ready of a 5-byte message. Required: exactly 1 byte transmitted; grant releases after GAP; a pending requester 1 is granted the next cycle after IDLE.
5. Async reset mid-byte. Assert rst_n=0 during WAIT_DONE. Required: grant, tx_valid, req_ready and timeout_err are 0 in the same cycle without a clock edge. After release, with req=01 held, byte 0 is re-latched from the current req_byte.
6. Gap timing. GAP_CYCLES=8 with busy falling at cycle T. Required: the next tx_valid rises at T+11 (8 gap + LATCH + SEND + register).
